imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: maximum number of 32-bit words written per load.
REQ-002 Parameter BASE_ADDR, default 32'h00000000: byte address of the first written word; word-aligned.
REQ-003 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begins a load when sampled high in IDLE; ignored in all other states.
REQ-006 finish  input  1  level request to end the load early; sampled only in ASSEMBLE.
REQ-007 byteIn  input  8  incoming program byte, big-endian within each word (first byte goes to bits 31:24).
REQ-008 byteValid  input  1  byteIn holds a valid byte this cycle.
REQ-009 byteReady  output  1  loader accepts a byte this cycle; a transfer occurs when byteValid and byteReady are both high.
REQ-010 memAddr  output  32  instruction memory write byte address.
REQ-011 memData  output  32  instruction memory write data.
REQ-012 memWe  output  1  single-cycle write strobe to instruction memory.
REQ-013 wordCount  output  16  number of words written in the current or most recent load.
REQ-014 busy  output  1  high in ASSEMBLE and WRITE.
REQ-015 cpuHold  output  1  equals busy; holds the program counter and fetch path frozen while memory is being written.
REQ-016 done  output  1  one-cycle pulse when a load completes.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ASSEMBLE, WRITE, DONE.
REQ-018 IDLE: byteReady=0, memWe=0; start=1 -> ASSEMBLE; memAddr<=BASE_ADDR, wordCount<=0, byte index<=0, assembly register<=0.
REQ-019 ASSEMBLE: byteReady=1; each transfer shifts byteIn into the assembly register (previous contents shift left 8) and increments the 2-bit byte index.
REQ-020 Acceptance of the 4th byte at edge k SHALL assert memWe for the cycle after edge k, state WRITE, with memData equal to the assembled word; byteReady=0 in WRITE.
REQ-021 WRITE lasts exactly one cycle; at its end memAddr<=memAddr+4 and wordCount<=wordCount+1; if the new wordCount equals DEPTH_WORDS -> DONE, else -> ASSEMBLE.
REQ-022 In ASSEMBLE with finish=1 and byteValid=0: byte index 0 -> DONE with no write; byte index 1-3 -> WRITE with the partial word left-aligned and unfilled low bytes zero.
REQ-023 byteValid=1 and finish=1 in the same ASSEMBLE cycle: the byte SHALL be accepted and finish ignored for that cycle.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; memAddr and wordCount hold their final values until the next start.
REQ-025 memAddr SHALL wrap modulo 2^32 with no error indication; wordCount never exceeds DEPTH_WORDS.
REQ-026 memWe SHALL never be high in more than one consecutive cycle, and never outside WRITE.

Reset
REQ-027 Rst=1 at a rising edge SHALL force IDLE, memAddr=BASE_ADDR, memData=0, wordCount=0, memWe=0, byteReady=0, busy=0, cpuHold=0, done=0, assembly register=0, byte index=0.
REQ-028 Rst takes priority over all inputs; Rst during WRITE SHALL drop memWe at that edge, and the partial word SHALL be discarded.
REQ-029 Rst SHALL NOT affect instruction memory contents already written.

Verification
REQ-030 Reset, then start with bytes 8C,01,00,04 back-to-back -> memWe one cycle after the 4th byte, memAddr=0, memData=32'h8C010004, wordCount=1 afterwards.
REQ-031 Two words with byteValid gaps of 3 cycles between bytes -> writes at addresses 0 and 4, busy=cpuHold=1 throughout, byteReady low only in WRITE cycles.
REQ-032 DEPTH_WORDS=2, feed 12 bytes -> exactly 2 writes, done pulses once, third-word bytes never accepted (byteReady=0 after DONE).
REQ-033 Bytes 12,34 then finish=1 -> write memData=32'h12340000 at memAddr=0, then done; finish with byte index 0 -> done without memWe.
REQ-034 Rst asserted in the WRITE cycle of word 2 -> memWe low after that edge, all outputs at reset values, next start restarts at BASE_ADDR.
REQ-035 start pulsed while busy -> no effect on memAddr, wordCount or state.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the
// imem_loader program loader.
//   master : drives start/finish/byteIn/byteValid, observes loader outputs
//   slave  : the loader itself
// Signals:
//   start, finish          load control (start in IDLE, finish level in ASSEMBLE)
//   byteIn[7:0], byteValid incoming program byte and its valid flag
//   byteReady              loader can accept a byte this cycle
//   memAddr[31:0]          write byte address
//   memData[31:0]          write data
//   memWe                  single-cycle write strobe
//   wordCount[15:0]        words written in the current/most recent load
//   busy, cpuHold          load in progress (CPU fetch frozen)
//   done                   one-cycle completion pulse
interface imem_loader_if;
  logic        start;
  logic        finish;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memWe;
  logic [15:0] wordCount;
  logic        busy;
  logic        cpuHold;
  logic        done;

  modport master (
    output start, finish, byteIn, byteValid,
    input  byteReady, memAddr, memData, memWe, wordCount, busy, cpuHold, done
  );

  modport slave (
    input  start, finish, byteIn, byteValid,
    output byteReady, memAddr, memData, memWe, wordCount, busy, cpuHold, done
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and
// writes them to instruction memory starting at BASE_ADDR, holding the CPU
// while the load runs.
// Parameters:
//   DEPTH_WORDS  maximum words written per load
//   BASE_ADDR    word-aligned byte address of the first word
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    imem_loader_if slave modport (byte input + memory write outputs)
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_i,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_e;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] asm_q, asm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      asm_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ASSEMBLE;
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
          idx_d   = '0;
          asm_d   = '0;
        end
      end
      ASSEMBLE: begin
        // A valid byte always wins over finish in the same cycle.
        if (bus.byteValid) begin
          asm_d = {asm_q[23:0], bus.byteIn};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end else if (bus.finish) begin
          if (idx_q == 2'd0) begin
            state_d = DONE;
          end else begin
            // Left-align the partial word; unfilled low bytes become zero.
            state_d = WRITE;
            idx_d   = '0;
            unique case (idx_q)
              2'd1:    asm_d = {asm_q[7:0],  24'h00_0000};
              2'd2:    asm_d = {asm_q[15:0], 16'h0000};
              default: asm_d = {asm_q[23:0], 8'h00};
            endcase
          end
        end
      end
      WRITE: begin
        // memAddr wraps naturally modulo 2^32.
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_inc;
        idx_d   = '0;
        asm_d   = '0;
        state_d = (cnt_inc == DEPTH_W) ? DONE : ASSEMBLE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; memory data is the assembly register itself.
  always_comb begin
    bus.byteReady = (state_q == ASSEMBLE);
    bus.memWe     = (state_q == WRITE);
    bus.busy      = (state_q == ASSEMBLE) || (state_q == WRITE);
    bus.cpuHold   = (state_q == ASSEMBLE) || (state_q == WRITE);
    bus.done      = (state_q == DONE);
    bus.memAddr   = addr_q;
    bus.memData   = asm_q;
    bus.wordCount = cnt_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Each load's expected writes are computed up front from the byte list:
// words grouped four bytes big-endian, capped at DEPTH words, last partial
// word left-aligned, addresses BASE + 4*i modulo 2^32.
module tb_imem_loader;

  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  bq[$];

  // Event counters owned by the monitor; snapshots owned by the driver
  int xfer_total = 0, we_total = 0, done_total = 0;
  int load_base_xfer = 0, load_base_we = 0, load_base_done = 0;
  bit load_active = 1'b0;

  // Monitor: samples 1 time unit after each rising edge
  bit          xfer_now;
  bit          prev_we = 1'b0;
  logic [31:0] ea, ed;

  always @(posedge clk) begin
    xfer_now = (bus.byteValid === 1'b1) && (bus.byteReady === 1'b1) && (rst === 1'b0);
    #1;
    if (xfer_now) begin
      xfer_total++;
      // Write strobe appears exactly in the cycle after the 4th byte of a word
      check_eq("we_after_byte", bus.memWe, ((xfer_total - load_base_xfer) % 4) == 0);
    end
    if (bus.memWe === 1'b1) begin
      check_eq("we_single", prev_we, 0);
      check_eq("we_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check_eq("mem_addr", bus.memAddr, ea);
        check_eq("mem_data", bus.memData, ed);
        check_eq("wc_at_write", bus.wordCount, we_total - load_base_we);
        check_eq("ready_in_write", bus.byteReady, 0);
      end
      we_total++;
    end
    if (load_active && done_total == load_base_done) begin
      if (bus.done === 1'b1) begin
        check_eq("busy_at_done", {bus.busy, bus.cpuHold, bus.byteReady, bus.memWe}, 0);
        check_eq("writes_left_at_done", exp_addr_q.size(), 0);
      end else begin
        check_eq("busy_hold", {bus.busy, bus.cpuHold}, 2'b11);
        check_eq("ready_vs_we", bus.byteReady, !bus.memWe);
      end
    end
    if (bus.done === 1'b1) done_total++;
    prev_we = (bus.memWe === 1'b1);
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_addr"}, bus.memAddr, BASE);
    check_eq({tag, "_data"}, bus.memData, 0);
    check_eq({tag, "_wc"}, bus.wordCount, 0);
    check_eq({tag, "_ctl"}, {bus.memWe, bus.byteReady, bus.busy, bus.cpuHold, bus.done}, 0);
  endtask

  // Runs one load with the bytes in bq; rst_after>0 asserts reset in the
  // WRITE cycle that follows acceptance of byte number rst_after.
  task automatic run_load(input int rst_after);
    int n, nacc, nw, gap;
    bit accepted;
    logic [31:0] w;
    n    = bq.size();
    nacc = (n < int'(4 * DEPTH)) ? n : int'(4 * DEPTH);
    nw   = (nacc + 3) / 4;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        w = w << 8;
        if (4 * i + j < nacc) w = w | {24'h0, bq[4 * i + j]};
      end
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_data_q.push_back(w);
    end

    load_base_xfer = xfer_total;
    load_base_we   = we_total;
    load_base_done = done_total;
    @(negedge clk);
    bus.start   = 1'b1;
    load_active = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.byteValid = 1'b0;
        bus.finish    = 1'b0;
        // start while busy must be ignored
        bus.start     = (i < nacc) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      bus.start     = 1'b0;
      bus.byteValid = 1'b1;
      bus.byteIn    = bq[i];
      bus.finish    = 1'($urandom_range(0, 1));
      accepted = 1'b0;
      for (int t = 0; t < 8 && !accepted; t++) begin
        accepted = (bus.byteReady === 1'b1);
        @(negedge clk);
      end
      check_eq("byte_accepted", accepted, i < nacc);
      if (rst_after > 0 && i + 1 == rst_after) begin
        // Now in the WRITE cycle of the word just completed
        rst           = 1'b1;
        load_active   = 1'b0;
        bus.byteValid = 1'b0;
        bus.finish    = 1'b0;
        @(posedge clk); #2;
        check_reset_outputs("rst_in_write");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (i >= nacc) break;
    end

    bus.byteValid = 1'b0;
    bus.finish    = 1'b1;
    for (int t = 0; t < 20 && done_total == load_base_done; t++) @(negedge clk);
    bus.finish  = 1'b0;
    load_active = 1'b0;
    @(posedge clk); #2;
    check_eq("done_pulses", done_total - load_base_done, 1);
    check_eq("bytes_accepted", xfer_total - load_base_xfer, nacc);
    check_eq("final_wc", bus.wordCount, nw);
    check_eq("final_addr", bus.memAddr, BASE + 32'(4 * nw));
    check_eq("idle_outputs", {bus.done, bus.busy, bus.cpuHold, bus.byteReady, bus.memWe}, 0);
    check_eq("writes_pending", exp_addr_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.finish    = 1'b0;
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single full word
    bq = '{8'h8C, 8'h01, 8'h00, 8'h04};
    run_load(0);
    // Partial word then finish
    bq = '{8'h12, 8'h34};
    run_load(0);
    // Finish with nothing assembled: done without a write
    bq.delete();
    run_load(0);
    // Overflow beyond DEPTH words: excess bytes never accepted
    bq.delete();
    for (int i = 0; i < int'(4 * DEPTH) + 2; i++) bq.push_back(8'($urandom_range(0, 255)));
    run_load(0);
    // Reset in the WRITE cycle of word 2, then restart from BASE
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom_range(0, 255)));
    run_load(8);
    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
    run_load(0);

    // Random loads
    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(0, 4 * DEPTH + 2);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      run_load(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
